// File: rtl/pc_pkg.sv
// Shared types for the fetch-PC generator: control-kind encoding, D-stage operand bundle.
// No logic beyond the is_cond helper; zero latency, no flow control.
// Default reset/exception vectors live here so top and bench agree.
package pc_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BGEZ = 4'd3,
        BR_BGTZ = 4'd4,
        BR_BLEZ = 4'd5,
        BR_BLTZ = 4'd6,
        BR_J    = 4'd7,
        BR_JAL  = 4'd8,
        BR_JR   = 4'd9,
        BR_JALR = 4'd10
    } br_kind_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;

    // Everything the D stage hands over to resolve one control instruction.
    typedef struct packed {
        br_kind_t    kind;
        logic [31:0] pc;
        logic [15:0] imm16;
        logic [25:0] index;
        logic [31:0] rs;
        logic [31:0] rt;
    } br_op_t;

    function automatic logic is_cond(input br_kind_t kind);
        return (kind == BR_BEQ)  || (kind == BR_BNE)  ||
               (kind == BR_BGEZ) || (kind == BR_BGTZ) ||
               (kind == BR_BLEZ) || (kind == BR_BLTZ);
    endfunction

endpackage

// File: rtl/pc_gen_br_resolve.sv
// D-stage branch/jump resolver: condition compare and redirect target.
// Purely combinational, zero latency.
// No backpressure; outputs follow the operands every cycle.
module br_resolve
    import pc_pkg::*;
(
    input  br_op_t      op,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        rs_neg;
    logic        rs_zero;

    assign pc4     = op.pc + 32'd4;
    assign br_tgt  = pc4 + {{14{op.imm16[15]}}, op.imm16, 2'b00};
    assign j_tgt   = {pc4[31:28], op.index, 2'b00};
    assign rs_neg  = op.rs[31];
    assign rs_zero = (op.rs == 32'd0);

    always_comb begin
        taken  = 1'b0;
        target = br_tgt;
        case (op.kind)
            BR_BEQ:  taken = (op.rs == op.rt);
            BR_BNE:  taken = (op.rs != op.rt);
            BR_BGEZ: taken = !rs_neg;
            BR_BGTZ: taken = !rs_neg && !rs_zero;
            BR_BLEZ: taken = rs_neg || rs_zero;
            BR_BLTZ: taken = rs_neg;
            BR_J, BR_JAL: begin
                taken  = 1'b1;
                target = j_tgt;
            end
            // Register jumps pass rs through untouched; misalignment is flagged at fetch.
            BR_JR, BR_JALR: begin
                taken  = 1'b1;
                target = op.rs;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC register with branch/jump redirect, exception/eret entry, BD/ADEL flags, branch counters.
// One-cycle latency from D-stage inputs to f_pc; d_taken and f_flush are combinational.
// stall holds PC, flags and counters; exc_req and eret_req override stall.
module pc_gen
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VEC    = EXC_VEC_DEFAULT,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_3000,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             f_is_ctrl,
    input  logic [3:0]       d_br_kind,
    input  logic [31:0]      d_pc,
    input  logic [15:0]      d_imm16,
    input  logic [25:0]      d_index,
    input  logic [31:0]      d_rs,
    input  logic [31:0]      d_rt,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [31:0]      epc,
    output logic [31:0]      f_pc,
    output logic             f_bd,
    output logic             f_adel,
    output logic             d_taken,
    output logic             f_flush,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // One bit wider so a window ending at 2^32 does not wrap to zero.
    localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < IMEM_BASE) || ({1'b0, a} >= IMEM_END);
    endfunction

    br_op_t      d_op;
    br_kind_t    kind;
    logic [31:0] target;
    logic [31:0] npc;
    logic        pc_load;
    logic        cnt_en;

    assign kind = br_kind_t'(d_br_kind);
    assign d_op = '{kind: kind, pc: d_pc, imm16: d_imm16, index: d_index, rs: d_rs, rt: d_rt};

    br_resolve u_br_resolve (
        .op     (d_op),
        .taken  (d_taken),
        .target (target)
    );

    assign f_flush = eret_req && !exc_req;
    assign cnt_en  = !stall && !exc_req && !eret_req && is_cond(kind);

    always_comb begin
        npc     = f_pc + 32'd4;
        pc_load = 1'b1;
        if (exc_req) begin
            npc = EXC_VEC;
        end else if (eret_req) begin
            npc = epc;
        end else if (stall) begin
            npc     = f_pc;
            pc_load = 1'b0;
        end else if (d_taken) begin
            npc = target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc   <= RESET_PC;
            f_bd   <= 1'b0;
            f_adel <= addr_err(RESET_PC);
        end else if (pc_load) begin
            f_pc   <= npc;
            f_bd   <= f_is_ctrl && !exc_req && !eret_req;
            f_adel <= addr_err(npc);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (cnt_en) begin
            br_cnt <= br_cnt + CNT_W'(1);
            if (d_taken) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Next-generation fetch-PC generator for the five-stage MIPS pipeline. It owns the F-stage PC register and resolves D-stage branches and jumps internally from raw operands; it no longer takes pre-computed compare flags.
- Adds stall hold, exception entry, eret return, a delay-slot (BD) flag, a fetch-address-error flag and branch performance counters.
- Sits between IM and the D-stage decoder/forwarding muxes; CP0 consumes f_bd and f_adel.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception handler entry.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_BYTES, 32'h0000_3000, size of the legal fetch window in bytes.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold the PC (load-use or multiply-busy hazard).
- f_is_ctrl  in  1  IM pre-decode: the instruction at f_pc is a branch or jump.
- d_br_kind  in  4  control kind of the D instruction (pkg encoding).
- d_pc  in  32  PC of the D instruction.
- d_imm16  in  16  branch offset, sign-extended internally.
- d_index  in  26  J-type instr_index.
- d_rs  in  32  forwarded rs value.
- d_rt  in  32  forwarded rt value.
- exc_req  in  1  CP0 exception entry request.
- eret_req  in  1  eret in D.
- epc  in  32  CP0 EPC.
- f_pc  out  32  current fetch PC.
- f_bd  out  1  the f_pc instruction is a delay slot.
- f_adel  out  1  the f_pc address is misaligned or outside the legal window.
- d_taken  out  1  the D control instruction redirects (combinational).
- f_flush  out  1  clear the IF/ID register next edge (eret; no delay slot).
- br_cnt  out  CNT_W  conditional branches resolved.
- taken_cnt  out  CNT_W  conditional branches taken.

Behaviour:
- Reset (reset=0, asynchronous):
  - f_pc=RESET_PC, f_bd=0, f_adel=adel(RESET_PC), br_cnt=0, taken_cnt=0.
  - Counters never reset mid-run except by reset.
- Branch resolution (combinational, D stage):
  - BEQ: rs==rt. BNE: rs!=rt.
  - BGEZ, BGTZ, BLEZ and BLTZ test signed rs against 0.
  - J/JAL/JR/JALR are always taken.
  - NONE gives d_taken=0.
- Targets:
  - Branch: d_pc+4+(sext(imm16)<<2), computed mod 2^32.
  - J/JAL: {d_pc[31:28]+... use (d_pc+4)[31:28], d_index, 2'b00}.
  - JR/JALR: d_rs, unaligned values allowed; f_adel flags them next cycle.
- Not-taken branches continue with f_pc+4. This equals d_pc+8, so the delay slot is already fetched.
- Next-PC priority at each edge, highest first:
  1. exc_req: EXC_VEC.
  2. eret_req: epc; f_flush=1 in that cycle.
  3. stall: hold f_pc, f_bd and f_adel; counters do not increment.
  4. d_taken: target.
  5. Otherwise: f_pc+4.
- Flags on each PC load:
  - f_adel <= (npc[1:0]!=0) || npc<IMEM_BASE || npc>=IMEM_BASE+IMEM_BYTES.
  - f_bd <= f_is_ctrl && !exc_req && !eret_req.
- exc_req and eret_req override stall. exc_req together with eret_req means exc_req wins and f_flush=0.
- Counters:
  - When not stalled and with no exc_req/eret_req, a conditional kind in D increments br_cnt and, if taken, taken_cnt.
  - Counters wrap at 2^CNT_W.
  - Unconditional jumps are not counted.
- f_flush is combinational (eret_req && !exc_req).
- Reset deasserting mid-operation restarts at RESET_PC. No other state survives.

Decomposition:
- Shared package pc_pkg holds:
  - the d_br_kind encoding: NONE=0, BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, J, JAL, JR, JALR;
  - the is_cond(kind) helper;
  - default RESET_PC and EXC_VEC.
- One sub-module, br_resolve: combinational compare plus target computation, outputting taken and target.
- Counters and the PC register stay in pc_gen.

Test Plan:
- Reset: release reset -> f_pc=0x3000, f_bd=0, f_adel=0, counters 0. Idle cycles -> f_pc 0x3004, 0x3008.
- BEQ taken: d_pc=0x3010, imm16=0xFFFC, rs=rt=5 -> d_taken=1, next f_pc=0x3004, br_cnt=1, taken_cnt=1. Repeat with rs=5, rt=6 -> next f_pc=f_pc+4, taken_cnt unchanged.
- BLTZ signed: rs=0x8000_0000 -> taken. rs=0 -> not taken. Likewise BGTZ with rs=0 -> not taken.
- Stall versus exception:
  - stall=1 with a taken JR in D -> f_pc and counters hold.
  - exc_req=1 while stall=1 -> f_pc=0x4180, f_bd=0.
- eret: eret_req=1, epc=0x3050 -> f_flush=1, next f_pc=0x3050. eret_req and exc_req together -> f_pc=0x4180, f_flush=0.
- Address error and BD flag:
  - JR with rs=0x3002 -> f_pc=0x3002, f_adel=1.
  - JR with rs=0x2FFC -> f_adel=1.
  - f_is_ctrl=1 on an advance -> f_bd=1 on the next cycle.
